// File: rtl/spi_slave_regbank.sv
// rtl/spi_slave_regbank.sv - SPI slave exposing a snapshot RO bank and an RW control bank
module spi_slave_regbank #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter int                NUM_RO      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 spi_sclk,
  input  logic                                 spi_mosi,
  input  logic                                 spi_ss_n,
  output logic                                 spi_miso,
  output logic                                 spi_miso_oe,
  input  logic [NUM_RO*DATA_W-1:0]             ro_data_i,
  output logic [(NUM_REGS-NUM_RO)*DATA_W-1:0]  rw_data_o,
  output logic [NUM_REGS-1:0]                  wr_strobe_o,
  output logic                                 frame_active,
  output logic                                 frame_err_o
);

  localparam int               NUM_RW    = NUM_REGS - NUM_RO;
  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic             IDLE_LVL  = (CPOL != 0);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, ss_sync;
  logic                    sclk_s, mosi_s, ss_s, sclk_prev, ss_prev;
  logic                    lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;
  logic [CNT_W-1:0]        bit_cnt, cnt_nxt;
  logic                    frame_start, cmd_done, word_done, err_set;
  logic [6:0]              cmd_sr, addr, cmd_addr, addr_inc;
  logic [7:0]              addr_p1;
  logic                    wr_mode, skip_shift;
  logic [DATA_W-1:0]       rx_sr, tx_sr, word;
  logic [DATA_W-1:0]       shadow [NUM_RO];
  logic [DATA_W-1:0]       rw_q   [NUM_RW];

  // ss_n chain resets to "selected" so a frame already in progress at reset
  // never produces a falling edge; the slave arms only after ss_n is seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_prev <= IDLE_LVL;
      ss_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev == IDLE_LVL) && (sclk_s != IDLE_LVL);
  assign trail_edge  = (sclk_prev != IDLE_LVL) && (sclk_s == IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev && !ss_s;
  assign ss_rise     = !ss_prev && ss_s;

  assign cmd_addr = {cmd_sr[5:0], mosi_s};
  assign word     = {rx_sr[DATA_W-2:0], mosi_s};
  assign addr_p1  = {1'b0, addr} + 8'd1;
  assign addr_inc = (addr_p1 == 8'(NUM_REGS)) ? 7'd0 : addr_p1[6:0];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    frame_start = 1'b0;
    cmd_done    = 1'b0;
    word_done   = 1'b0;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_fall) begin
          state_nxt   = S_CMD;
          cnt_nxt     = '0;
          frame_start = 1'b1;
        end
      end
      S_CMD: begin
        if (sample_edge) begin
          if (bit_cnt == CMD_LAST) begin
            cmd_done  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_DATA;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_edge) begin
          if (bit_cnt == WORD_LAST) begin
            word_done = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A word finishing on the same clock as ss_n rising leaves cnt_nxt at 0,
    // so it commits cleanly instead of being flagged as partial.
    if (state != S_IDLE && ss_rise) begin
      state_nxt = S_IDLE;
      err_set   = (cnt_nxt != '0);
    end
  end

  function automatic logic [DATA_W-1:0] read_reg(input logic [6:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_RO; r++)
      if ({1'b0, a} == 8'(r)) v = shadow[r];
    for (int k = 0; k < NUM_RW; k++)
      if ({1'b0, a} == 8'(NUM_RO + k)) v = rw_q[k];
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      addr        <= '0;
      wr_mode     <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      skip_shift  <= 1'b0;
      shadow      <= '{default: '0};
      rw_q        <= '{default: RESET_VAL};
      wr_strobe_o <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= cnt_nxt;
      wr_strobe_o <= '0;
      frame_err_o <= err_set;
      if (frame_start) begin
        for (int r = 0; r < NUM_RO; r++) shadow[r] <= ro_data_i[r*DATA_W +: DATA_W];
        tx_sr      <= '0;
        skip_shift <= 1'b0;
      end
      if (state == S_CMD && sample_edge) cmd_sr <= {cmd_sr[5:0], mosi_s};
      if (cmd_done) begin
        wr_mode    <= cmd_sr[6];
        addr       <= cmd_addr;
        tx_sr      <= cmd_sr[6] ? '0 : read_reg(cmd_addr);
        skip_shift <= 1'b1;
      end
      if (state == S_DATA && sample_edge) rx_sr <= word;
      // The shift edge right after a load only releases the MSB already on miso.
      if (state == S_DATA && shift_edge) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_sr      <= {tx_sr[DATA_W-2:0], 1'b0};
      end
      if (word_done) begin
        if (wr_mode) begin
          if ({1'b0, addr} >= 8'(NUM_RO) && {1'b0, addr} < 8'(NUM_REGS)) begin
            for (int k = 0; k < NUM_RW; k++) begin
              if ({1'b0, addr} == 8'(NUM_RO + k)) begin
                rw_q[k]                <= word;
                wr_strobe_o[NUM_RO + k] <= 1'b1;
              end
            end
          end else begin
            frame_err_o <= 1'b1;
          end
        end else begin
          tx_sr      <= read_reg(addr_inc);
          skip_shift <= 1'b1;
        end
        addr <= addr_inc;
      end
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
    assign rw_data_o[k*DATA_W +: DATA_W] = rw_q[k];
  end

  assign frame_active = (state != S_IDLE);
  assign spi_miso_oe  = frame_active;
  assign spi_miso     = (state == S_DATA && !wr_mode) ? tx_sr[DATA_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb/tb_spi_slave_regbank.sv - scoreboard bench for spi_slave_regbank in all four SPI modes
module tb_spi_slave_regbank;

  localparam int HALF = 80;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   sclk = 4'b1100;
  logic [3:0]   ss_n = 4'hF;
  logic         mosi = 1'b0;
  logic [3:0]   miso, oe, fa, ferr;
  logic [255:0] ro_data = '0;
  logic [255:0] rw_data [4];
  logic [15:0]  strobe  [4];

  int           checks = 0;
  int           errors = 0;
  int           err_cnt = 0;
  int           exp_err = 0;
  logic         ferr_q = 1'b0;
  wr_t          exp_wr[$];
  logic [127:0] exp_rd[$];
  logic [127:0] rx;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_regbank #(.CPOL(g / 2), .CPHA(g % 2)) dut (
      .clk          (clk),
      .reset        (rst),
      .spi_sclk     (sclk[g]),
      .spi_mosi     (mosi),
      .spi_ss_n     (ss_n[g]),
      .spi_miso     (miso[g]),
      .spi_miso_oe  (oe[g]),
      .ro_data_i    (ro_data),
      .rw_data_o    (rw_data[g]),
      .wr_strobe_o  (strobe[g]),
      .frame_active (fa[g]),
      .frame_err_o  (ferr[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ferr[0]) begin
        err_cnt++;
        check("err_pulse_width", 128'(ferr_q), 128'(0));
      end
      ferr_q = ferr[0];
      if (strobe[0] != 16'h0) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_strobe", 128'(strobe[0]), 128'(0));
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_strobe", 128'(strobe[0]), 128'(16'(1) << w.addr));
          check("wr_data", 128'(rw_data[0][(w.addr - 8)*32 +: 32]), 128'(w.data));
        end
      end
    end
  end

  task automatic spi_xfer(input int m, input int nbits, input logic [127:0] tx,
                          output logic [127:0] rxo);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rxo = '0;
    ss_n[m] = 1'b0;
    #HALF;
    check("frame_active", 128'(fa[m]), 128'(1));
    check("miso_oe", 128'(oe[m]), 128'(1));
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        #HALF;
        rxo = {rxo[126:0], miso[m]};
        sclk[m] = ~cpol;
        #HALF;
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = tx[i];
        #HALF;
        rxo = {rxo[126:0], miso[m]};
        sclk[m] = cpol;
        #HALF;
      end
    end
    #HALF;
    ss_n[m] = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
    check("frame_idle", 128'(fa[m]), 128'(0));
  endtask

  task automatic write_frame(input int m, input int a, input logic [31:0] d);
    logic [127:0] r;
    if (m == 0 && a >= 8 && a < 16) exp_wr.push_back('{addr: a, data: d});
    spi_xfer(m, 40, {88'h0, 1'b1, a[6:0], d}, r);
  endtask

  task automatic read_check(input int m, input int a, input logic [31:0] e, input string tag);
    logic [127:0] r;
    exp_rd.push_back(128'(e));
    spi_xfer(m, 40, {88'h0, 1'b0, a[6:0], 32'h0}, r);
    check(tag, 128'(r[31:0]), exp_rd.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #20;
    rst = 1'b0;
    #10;
    check("reset_rw", 128'(rw_data[0]), 128'(0));
    check("reset_strobe", 128'(strobe[0]), 128'(0));
    check("reset_miso", 128'(miso[0]), 128'(0));
    check("reset_oe", 128'(oe[0]), 128'(0));
    check("reset_active", 128'(fa[0]), 128'(0));
    #100;

    // T1: plain write into reg10
    write_frame(0, 10, 32'hDEADBEEF);
    check("t1_reg10", 128'(rw_data[0][2*32 +: 32]), 128'(32'hDEADBEEF));

    // T2: snapshot held despite mid-frame input change; next frame sees new value
    ro_data[3*32 +: 32] = 32'h12345678;
    exp_rd.push_back(128'(32'h12345678));
    fork
      spi_xfer(0, 40, {88'h0, 8'h03, 32'h0}, rx);
      begin
        #(HALF + 20*2*HALF);
        ro_data[3*32 +: 32] = 32'hFFFF0000;
      end
    join
    check("t2_snapshot", 128'(rx[31:0]), exp_rd.pop_front());
    read_check(0, 3, 32'hFFFF0000, "t2_next_frame");
    read_check(0, 127, 32'h0, "t2_out_of_range");

    // T3: burst write from 15 wraps onto RO reg0, second word dropped
    exp_wr.push_back('{addr: 15, data: 32'hA5A5A5A5});
    exp_err++;
    spi_xfer(0, 72, {56'h0, 8'h8F, 32'hA5A5A5A5, 32'hB4B4B4B4}, rx);
    check("t3_reg15", 128'(rw_data[0][7*32 +: 32]), 128'(32'hA5A5A5A5));
    check("t3_err_count", 128'(err_cnt), 128'(exp_err));

    // T4: every CPOL/CPHA mode, burst write reg8/reg9 then burst read back
    for (int m = 0; m < 4; m++) begin
      logic [31:0] w9;
      w9 = 32'h3C000000 + 32'(m * 17);
      if (m == 0) begin
        exp_wr.push_back('{addr: 8, data: 32'h0F0F0F0F});
        exp_wr.push_back('{addr: 9, data: w9});
      end
      spi_xfer(m, 72, {56'h0, 8'h88, 32'h0F0F0F0F, w9}, rx);
      check("t4_reg8_out", 128'(rw_data[m][31:0]), 128'(32'h0F0F0F0F));
      exp_rd.push_back({64'h0, 32'h0F0F0F0F, w9});
      spi_xfer(m, 72, {56'h0, 8'h08, 64'h0}, rx);
      check("t4_burst_read", 128'(rx[63:0]), exp_rd.pop_front());
    end

    // T5: truncated word is discarded and flagged; a full frame then succeeds
    exp_err++;
    spi_xfer(0, 28, {100'h0, 8'h89, 20'hABCDE}, rx);
    check("t5_reg9_kept", 128'(rw_data[0][1*32 +: 32]), 128'(32'h3C000000));
    check("t5_err_count", 128'(err_cnt), 128'(exp_err));
    write_frame(0, 9, 32'hCAFEF00D);
    read_check(0, 9, 32'hCAFEF00D, "t5_reg9_read");

    // T6: reset at bit 12 of a write word
    fork
      spi_xfer(0, 40, {88'h0, 8'h8B, 32'h13579BDF}, rx);
      begin
        #(HALF + 20*2*HALF + 40);
        rst = 1'b1;
        #30;
        rst = 1'b0;
        #10;
        check("t6_rw_reset", 128'(rw_data[0]), 128'(0));
      end
    join
    check("t6_rw_after_frame", 128'(rw_data[0]), 128'(0));
    check("t6_err_count", 128'(err_cnt), 128'(exp_err));
    write_frame(0, 11, 32'h55AA55AA);
    read_check(0, 11, 32'h55AA55AA, "t6_next_frame");

    #200;
    check("wr_queue_drained", 128'(exp_wr.size()), 128'(0));
    check("final_err_count", 128'(err_cnt), 128'(exp_err));
    check("idle_miso", 128'(miso[0]), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
